// File: rtl/mcm_random_pq_driver.sv
// mcm_random_pq_driver
//   Initiator for the masked multiplier. Takes one job (p1, p2, p_det) from the
//   control path, fills NR random words from a 32-bit Galois LFSR, strobes the
//   multiplier for one cycle, then waits (bounded by TMO) for its result and
//   returns it upstream on a valid/ready port.
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   seed_load, seed          reseed the LFSR while idle (zero seed maps to 1)
//   req_valid/ready, req_*   job request (operands, field selector)
//   mul_drdy_i, mul_*        start strobe and operands/random vector to multiplier
//   mul_drdy_o, mul_out      multiplier result pulse and data
//   res_valid/ready          result handshake
//   res_data, res_err        product, or zero with res_err=1 on timeout
module mcm_random_pq_driver #(
    parameter int D       = 1,
    parameter int RP_W    = 8,
    parameter int STATE_W = 256,
    parameter int PDET_W  = 4,
    parameter int TMO     = 255,
    localparam int NR     = 2 * (8 + D)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [STATE_W-1:0]   req_p1,
    input  logic [STATE_W-1:0]   req_p2,
    input  logic [PDET_W-1:0]    req_p_det,
    output logic                 mul_drdy_i,
    output logic [STATE_W-1:0]   mul_p1,
    output logic [STATE_W-1:0]   mul_p2,
    output logic [PDET_W-1:0]    mul_p_det,
    output logic [NR*RP_W-1:0]   mul_rand,
    input  logic                 mul_drdy_o,
    input  logic [STATE_W-1:0]   mul_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [STATE_W-1:0]   res_data,
    output logic                 res_err
);

    localparam int RW    = NR * RP_W;
    localparam int CNT_W = $clog2(NR);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {IDLE, FILL, FIRE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          lfsr_q, lfsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           tmo_q, tmo_d;
    logic [STATE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
    logic [PDET_W-1:0]    pdet_q, pdet_d;
    logic [RW-1:0]        rand_q, rand_d;
    logic [STATE_W-1:0]   data_q, data_d;
    logic                 err_q, err_d;
    logic [31:0]          lfsr_step;

    // Right-shifting Galois form: the bit shifted out folds the tap mask back in.
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        pdet_d  = pdet_q;
        rand_d  = rand_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // Seed and request may land together; the job then uses the new seed.
                if (seed_load)
                    lfsr_d = (seed == 32'd0) ? 32'h0000_0001 : seed;
                if (req_valid) begin
                    p1_d    = req_p1;
                    p2_d    = req_p2;
                    pdet_d  = req_p_det;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Word 0 sits in the MSBs of the random vector.
                for (int w = 0; w < NR; w++)
                    if (cnt_q == CNT_W'(w))
                        rand_d[RW-RP_W*(w+1) +: RP_W] = lfsr_q[RP_W-1:0];
                lfsr_d = lfsr_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NR-1))
                    state_d = FIRE;
            end
            FIRE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving in the last permitted cycle still beats the timeout.
                if (mul_drdy_o) begin
                    data_d  = mul_out;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (tmo_q == 8'(TMO)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= 32'h0000_0001;
            cnt_q   <= '0;
            tmo_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            pdet_q  <= '0;
            rand_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            pdet_q  <= pdet_d;
            rand_q  <= rand_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mul_drdy_i = (state_q == FIRE);
    assign res_valid  = (state_q == DONE);
    assign mul_p1     = p1_q;
    assign mul_p2     = p2_q;
    assign mul_p_det  = pdet_q;
    assign mul_rand   = rand_q;
    assign res_data   = data_q;
    assign res_err    = err_q;

endmodule
